rv32i_decode_execute: RTL and testbench
=======================================

# rv32i_decode_execute

Combined decode/control/execute block for the single-issue RV32I core. It latches the fetched instruction and PC and splits the instruction into fields and a sign-extended immediate. It also generates datapath control and computes the ALU result and branch decision. It sits between fetch/instruction memory and the data memory/writeback logic; register-file reads and forwarding stay outside it.

## Interface
- AWIDTH, 32, address/PC width
- DWIDTH, 32, data width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, asynchronous, active-high
- insn_i  in  DWIDTH  fetched instruction
- pc_i  in  AWIDTH  PC of insn_i
- rs1data_i / rs2data_i  in  DWIDTH  (forwarded) register operands
- pc_o / insn_o  out  AWIDTH / DWIDTH  latched PC / instruction
- opcode_o 7, rd_o 5, funct3_o 3, rs1_o 5, rs2_o 5, funct7_o 7, shamt_o 5  out  instruction fields
- imm_o  out  32  sign-extended immediate
- pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o  out  1  controls
- wbsel_o  out  2  00 ALU, 01 memory, 10 PC+4
- alusel_o  out  4  ALU operation
- res_o  out  DWIDTH  ALU result
- brtaken_o  out  1  redirect taken
- illegal_o  out  1  unrecognised opcode (see Configuration)

## Operation
- Fields come from insn_o: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25], shamt[24:20].
- Immediate by opcode:
  - I-type for 0x13/0x03/0x67.
  - S-type for 0x23.
  - B-type for 0x63, bit0=0.
  - U-type for 0x37/0x17, low 12 bits zero.
  - J-type for 0x6F.
  - 0 for any other opcode.
- alusel codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- Operand A = rs1sel ? pc_o : rs1data_i.
- Operand B = rs2sel ? imm_o : rs2data_i.
- Shifts use B[4:0]; SLT is signed, SLTU unsigned.
- R-type (0x33): funct3/funct7 select the op; funct7[5] selects SUB/SRA. regwren=1, wbsel=00.
- I-ALU (0x13): rs2sel=1, immsel=1. funct7[5] matters only for SRAI. ADDI is never SUB.
- LUI: PASS_B. AUIPC: rs1sel=1, ADD.
- Loads (0x03): ADD, memren=1, wbsel=01, regwren=1.
- Stores (0x23): ADD, memwren=1, regwren=0.
- Branches (0x63): rs1sel=rs2sel=1, ADD, so res = PC+imm target.
- Branch condition from rs1data_i vs rs2data_i: BEQ, BNE, BLT, BGE, BLTU, BGEU. pcsel=1, regwren=0.
- JAL: res = pc+imm. JALR: res = (rs1+imm) & ~1.
- Both jumps: brtaken=1, pcsel=1, regwren=1, wbsel=10.
- brtaken=0 for non-control-flow instructions.
- ECALL/system (0x73): all write/mem enables 0.
- Unknown opcode: all enables 0, brtaken=0.
- Writes with rd=0 keep regwren as decoded; the register file ignores them.

## Timing
- pc_o/insn_o register on the rising clk edge from pc_i/insn_i.
- On rst assertion, without waiting for a clock: pc_o=0 and insn_o=0x00000013 (NOP). All outputs then show NOP decode: opcode 0x13, rd 0, imm 0, regwren 1, res = rs1data_i, brtaken 0.
- Reset mid-operation discards the latched instruction immediately.
- Latency: fields, controls, res and brtaken are valid combinationally one cycle after insn_i is sampled.
- res and brtaken also follow rs*data_i combinationally in the same cycle.
- No stall or handshake: a new instruction is accepted every cycle.

## Configuration
- ILLEGAL_INSN_EN defined: illegal_o=1 for any opcode outside the RV32I set (0x33, 0x13, 0x03, 0x23, 0x63, 0x6F, 0x67, 0x37, 0x17, 0x73, 0x0F). Controls are forced to no-effect while illegal_o=1.
- ILLEGAL_INSN_EN undefined: illegal_o tied 0; unknown opcodes still decode with all enables 0.

## Test plan
- Reset mid-run with rst=1, rs1data_i=0x55 -> pc_o=0, insn_o=0x00000013, res_o=0x55, regwren_o=1, rd_o=0, with no clock edge.
- Latch insn 0x00500093 at pc 0x01000000, rs1data_i=0 -> opcode 0x13, rd 1, imm 5, res 5, wbsel 00.
- Latch 0x40208133 with rs1data_i=3, rs2data_i=5 -> alusel SUB, res 0xFFFFFFFE, regwren 1.
- Latch 0x00208463 at pc 0x01000010:
  - rs1data_i = rs2data_i = 7 -> brtaken 1, res 0x01000018.
  - rs2data_i = 8 -> brtaken 0.
- Latch 0xFFC0A183 with rs1data_i=0x02000010 -> imm 0xFFFFFFFC, res 0x0200000C, memren 1, wbsel 01.
- Latch 0x00008067 with rs1data_i=0x01000105 -> res 0x01000104, brtaken 1, pcsel 1, wbsel 10.
- Latch opcode 0x7F -> illegal_o=1 with the macro, 0 without; all enables 0 in both builds.

Source files
------------

// File: rtl/rv32i_decode_execute.sv
// rv32i_decode_execute: latches the fetched RV32I instruction and PC, splits it
// into fields and a sign-extended immediate, generates datapath controls, and
// computes the ALU result and branch/jump decision.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   insn_i, pc_i              fetched instruction and its PC
//   rs1data_i, rs2data_i      forwarded register operands
//   pc_o, insn_o              latched PC / instruction (reset: 0 / NOP)
//   opcode_o..shamt_o, imm_o  decoded fields and sign-extended immediate
//   pcsel_o..wbsel_o,alusel_o datapath controls
//   res_o, brtaken_o          ALU result and redirect decision (combinational)
//   illegal_o                 unrecognised opcode flag
//
// Build option: define ILLEGAL_INSN_EN to drive illegal_o for opcodes outside
// the RV32I base set; otherwise illegal_o is tied low.
module rv32i_decode_execute #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] insn_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] rs1data_i,
    input  logic [DWIDTH-1:0] rs2data_i,
    output logic [AWIDTH-1:0] pc_o,
    output logic [DWIDTH-1:0] insn_o,
    output logic [6:0]        opcode_o,
    output logic [4:0]        rd_o,
    output logic [2:0]        funct3_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o,
    output logic [6:0]        funct7_o,
    output logic [4:0]        shamt_o,
    output logic [31:0]       imm_o,
    output logic              pcsel_o,
    output logic              immsel_o,
    output logic              regwren_o,
    output logic              rs1sel_o,
    output logic              rs2sel_o,
    output logic              memren_o,
    output logic              memwren_o,
    output logic [1:0]        wbsel_o,
    output logic [3:0]        alusel_o,
    output logic [DWIDTH-1:0] res_o,
    output logic              brtaken_o,
    output logic              illegal_o
);

    localparam logic [6:0] OP_R      = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    logic [3:0]        alu_fn;
    logic [DWIDTH-1:0] op_a;
    logic [DWIDTH-1:0] op_b;
    logic [DWIDTH-1:0] alu_out;
    logic              br_cond;

    // Instruction/PC latch; reset injects a NOP immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_o   <= '0;
            insn_o <= DWIDTH'(32'h0000_0013);
        end else begin
            pc_o   <= pc_i;
            insn_o <= insn_i;
        end
    end

    assign opcode_o = insn_o[6:0];
    assign rd_o     = insn_o[11:7];
    assign funct3_o = insn_o[14:12];
    assign rs1_o    = insn_o[19:15];
    assign rs2_o    = insn_o[24:20];
    assign funct7_o = insn_o[31:25];
    assign shamt_o  = insn_o[24:20];

    // Immediate formats.
    always_comb begin
        imm_o = '0;
        case (opcode_o)
            OP_IMM, OP_LOAD, OP_JALR: imm_o = {{20{insn_o[31]}}, insn_o[31:20]};
            OP_STORE:  imm_o = {{20{insn_o[31]}}, insn_o[31:25], insn_o[11:7]};
            OP_BRANCH: imm_o = {{19{insn_o[31]}}, insn_o[31], insn_o[7],
                                insn_o[30:25], insn_o[11:8], 1'b0};
            OP_LUI, OP_AUIPC: imm_o = {insn_o[31:12], 12'h000};
            OP_JAL:    imm_o = {{11{insn_o[31]}}, insn_o[31], insn_o[19:12],
                                insn_o[20], insn_o[30:21], 1'b0};
            default:   imm_o = '0;
        endcase
    end

    // ALU op for R-type / I-ALU; SUB only exists in the register form.
    always_comb begin
        alu_fn = ALU_ADD;
        case (funct3_o)
            3'd0:    alu_fn = (opcode_o == OP_R && funct7_o[5]) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_fn = ALU_SLL;
            3'd2:    alu_fn = ALU_SLT;
            3'd3:    alu_fn = ALU_SLTU;
            3'd4:    alu_fn = ALU_XOR;
            3'd5:    alu_fn = funct7_o[5] ? ALU_SRA : ALU_SRL;
            3'd6:    alu_fn = ALU_OR;
            default: alu_fn = ALU_AND;
        endcase
    end

    // Control decode; unknown, system and fence opcodes leave every enable low.
    always_comb begin
        pcsel_o   = 1'b0;
        immsel_o  = 1'b0;
        regwren_o = 1'b0;
        rs1sel_o  = 1'b0;
        rs2sel_o  = 1'b0;
        memren_o  = 1'b0;
        memwren_o = 1'b0;
        wbsel_o   = 2'b00;
        alusel_o  = ALU_ADD;
        case (opcode_o)
            OP_R: begin
                regwren_o = 1'b1;
                alusel_o  = alu_fn;
            end
            OP_IMM: begin
                regwren_o = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
                alusel_o  = alu_fn;
            end
            OP_LOAD: begin
                regwren_o = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
                memren_o  = 1'b1;
                wbsel_o   = 2'b01;
            end
            OP_STORE: begin
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
                memwren_o = 1'b1;
            end
            OP_BRANCH: begin
                pcsel_o   = 1'b1;
                rs1sel_o  = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
            end
            OP_JAL: begin
                pcsel_o   = 1'b1;
                regwren_o = 1'b1;
                rs1sel_o  = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
                wbsel_o   = 2'b10;
            end
            OP_JALR: begin
                pcsel_o   = 1'b1;
                regwren_o = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
                wbsel_o   = 2'b10;
            end
            OP_LUI: begin
                regwren_o = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
                alusel_o  = ALU_PASSB;
            end
            OP_AUIPC: begin
                regwren_o = 1'b1;
                rs1sel_o  = 1'b1;
                rs2sel_o  = 1'b1;
                immsel_o  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_INSN_EN
    // Anything outside the RV32I base opcode set.
    always_comb begin
        illegal_o = 1'b1;
        case (opcode_o)
            7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
            7'h67, 7'h37, 7'h17, 7'h73, 7'h0F: illegal_o = 1'b0;
            default: illegal_o = 1'b1;
        endcase
    end
`else
    assign illegal_o = 1'b0;
`endif

    assign op_a = rs1sel_o ? DWIDTH'(pc_o) : rs1data_i;
    assign op_b = rs2sel_o ? DWIDTH'(imm_o) : rs2data_i;

    // ALU; shift amount is operand B[4:0].
    always_comb begin
        alu_out = '0;
        case (alusel_o)
            ALU_ADD:   alu_out = op_a + op_b;
            ALU_SUB:   alu_out = op_a - op_b;
            ALU_SLL:   alu_out = op_a << op_b[4:0];
            ALU_SLT:   alu_out = DWIDTH'($signed(op_a) < $signed(op_b));
            ALU_SLTU:  alu_out = DWIDTH'(op_a < op_b);
            ALU_XOR:   alu_out = op_a ^ op_b;
            ALU_SRL:   alu_out = op_a >> op_b[4:0];
            ALU_SRA:   alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            ALU_OR:    alu_out = op_a | op_b;
            ALU_AND:   alu_out = op_a & op_b;
            ALU_PASSB: alu_out = op_b;
            default:   alu_out = op_a + op_b;
        endcase
    end

    // JALR target has bit 0 cleared.
    assign res_o = (opcode_o == OP_JALR) ? {alu_out[DWIDTH-1:1], 1'b0} : alu_out;

    // Branch condition compares the register operands, not the ALU inputs.
    always_comb begin
        br_cond = 1'b0;
        case (funct3_o)
            3'd0:    br_cond = (rs1data_i == rs2data_i);
            3'd1:    br_cond = (rs1data_i != rs2data_i);
            3'd4:    br_cond = ($signed(rs1data_i) <  $signed(rs2data_i));
            3'd5:    br_cond = ($signed(rs1data_i) >= $signed(rs2data_i));
            3'd6:    br_cond = (rs1data_i <  rs2data_i);
            3'd7:    br_cond = (rs1data_i >= rs2data_i);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        brtaken_o = 1'b0;
        case (opcode_o)
            OP_BRANCH:       brtaken_o = br_cond;
            OP_JAL, OP_JALR: brtaken_o = 1'b1;
            default:         brtaken_o = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
// Bench for rv32i_decode_execute: reference model of RV32I decode/execute
// semantics checked every falling edge, plus literal expectations.
module tb_rv32i_decode_execute;

    logic        clk;
    logic        rst;
    logic [31:0] insn_i, pc_i, rs1data_i, rs2data_i;
    logic [31:0] pc_o, insn_o, imm_o, res_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [4:0]  rd_o, rs1_o, rs2_o, shamt_o;
    logic [2:0]  funct3_o;
    logic        pcsel_o, immsel_o, regwren_o, rs1sel_o, rs2sel_o, memren_o, memwren_o;
    logic [1:0]  wbsel_o;
    logic [3:0]  alusel_o;
    logic        brtaken_o, illegal_o;

    int n_checks = 0;
    int n_pass   = 0;

    rv32i_decode_execute #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst), .insn_i(insn_i), .pc_i(pc_i),
        .rs1data_i(rs1data_i), .rs2data_i(rs2data_i),
        .pc_o(pc_o), .insn_o(insn_o), .opcode_o(opcode_o), .rd_o(rd_o),
        .funct3_o(funct3_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .funct7_o(funct7_o),
        .shamt_o(shamt_o), .imm_o(imm_o), .pcsel_o(pcsel_o), .immsel_o(immsel_o),
        .regwren_o(regwren_o), .rs1sel_o(rs1sel_o), .rs2sel_o(rs2sel_o),
        .memren_o(memren_o), .memwren_o(memwren_o), .wbsel_o(wbsel_o),
        .alusel_o(alusel_o), .res_o(res_o), .brtaken_o(brtaken_o),
        .illegal_o(illegal_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] imm;
        logic [31:0] res;
        logic        res_valid;
        logic        br, pcsel, immsel, regwren, rs1sel, rs2sel, memren, memwren, illegal;
        logic [1:0]  wbsel;
        logic [3:0]  alusel;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, want, $time);
    endtask

    function automatic logic [31:0] sext_top(input logic [31:0] insn, input int unsigned keep);
        // arithmetic shift of the whole word keeps the sign of bit 31
        return $unsigned($signed(insn) >>> (32 - keep));
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] insn);
        logic [31:0] sign;
        sign = insn[31] ? 32'hFFFF_FFFF : 32'h0;
        case (insn[6:0])
            7'h13, 7'h03, 7'h67: return sext_top(insn, 12);
            7'h23: return (sext_top(insn, 7) << 5) + ((insn >> 7) & 32'h1F);
            7'h63: return (sign & 32'hFFFF_F000) + ((insn >> 7) & 32'h1) * 2048
                          + ((insn >> 25) & 32'h3F) * 32 + ((insn >> 8) & 32'hF) * 2;
            7'h37, 7'h17: return insn & 32'hFFFF_F000;
            7'h6F: return (sign & 32'hFFF0_0000) + (insn & 32'h000F_F000)
                          + ((insn >> 20) & 32'h1) * 2048 + ((insn >> 21) & 32'h3FF) * 2;
            default: return 32'h0;
        endcase
    endfunction

    // Arithmetic meaning of funct3 (and bit 30 where it matters).
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                            input logic is_r, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0: return (is_r && alt) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return alt ? $unsigned($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic [3:0] ref_code(input logic [2:0] f3, input logic alt, input logic is_r);
        case (f3)
            3'd0: return (is_r && alt) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return alt ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] insn, input logic [31:0] pc,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [2:0] f3;
        logic       alt;
        f3 = insn[14:12];
        alt = insn[30];
        e = '{default: '0};
        e.imm = ref_imm(insn);
        e.res_valid = 1'b1;
        case (insn[6:0])
            7'h33: begin
                e.regwren = 1; e.alusel = ref_code(f3, alt, 1); e.res = ref_alu(f3, alt, 1, a, b);
            end
            7'h13: begin
                e.regwren = 1; e.rs2sel = 1; e.immsel = 1;
                e.alusel = ref_code(f3, alt, 0); e.res = ref_alu(f3, alt, 0, a, e.imm);
            end
            7'h03: begin
                e.regwren = 1; e.rs2sel = 1; e.immsel = 1; e.memren = 1; e.wbsel = 2'b01;
                e.res = a + e.imm;
            end
            7'h23: begin
                e.rs2sel = 1; e.immsel = 1; e.memwren = 1; e.res = a + e.imm;
            end
            7'h63: begin
                e.pcsel = 1; e.rs1sel = 1; e.rs2sel = 1; e.immsel = 1; e.res = pc + e.imm;
                case (f3)
                    3'd0: e.br = (a == b);
                    3'd1: e.br = (a != b);
                    3'd4: e.br = ($signed(a) < $signed(b));
                    3'd5: e.br = ($signed(a) >= $signed(b));
                    3'd6: e.br = (a < b);
                    3'd7: e.br = (a >= b);
                    default: e.br = 0;
                endcase
            end
            7'h6F: begin
                e.pcsel = 1; e.regwren = 1; e.rs1sel = 1; e.rs2sel = 1; e.immsel = 1;
                e.wbsel = 2'b10; e.br = 1; e.res = pc + e.imm;
            end
            7'h67: begin
                e.pcsel = 1; e.regwren = 1; e.rs2sel = 1; e.immsel = 1;
                e.wbsel = 2'b10; e.br = 1; e.res = (a + e.imm) & ~32'h1;
            end
            7'h37: begin
                e.regwren = 1; e.rs2sel = 1; e.immsel = 1; e.alusel = 4'd10; e.res = e.imm;
            end
            7'h17: begin
                e.regwren = 1; e.rs1sel = 1; e.rs2sel = 1; e.immsel = 1; e.res = pc + e.imm;
            end
            7'h73, 7'h0F: e.res_valid = 0;
            default: begin
                e.res_valid = 0;
`ifdef ILLEGAL_INSN_EN
                e.illegal = 1;
`endif
            end
        endcase
        return e;
    endfunction

    // Architectural view of what the block should currently hold.
    logic [31:0] m_pc, m_insn;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc   <= 32'h0;
            m_insn <= 32'h0000_0013;
        end else begin
            m_pc   <= pc_i;
            m_insn <= insn_i;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        exp_t e;
        e = model(m_insn, m_pc, rs1data_i, rs2data_i);
        chk("pc_o", pc_o, m_pc);
        chk("insn_o", insn_o, m_insn);
        chk("opcode", 32'(opcode_o), m_insn % 128);
        chk("rd", 32'(rd_o), (m_insn / 128) % 32);
        chk("funct3", 32'(funct3_o), (m_insn / 4096) % 8);
        chk("rs1", 32'(rs1_o), (m_insn / 32768) % 32);
        chk("rs2", 32'(rs2_o), (m_insn / 1048576) % 32);
        chk("shamt", 32'(shamt_o), (m_insn / 1048576) % 32);
        chk("funct7", 32'(funct7_o), m_insn / 33554432);
        chk("imm", imm_o, e.imm);
        chk("pcsel", 32'(pcsel_o), 32'(e.pcsel));
        chk("immsel", 32'(immsel_o), 32'(e.immsel));
        chk("regwren", 32'(regwren_o), 32'(e.regwren));
        chk("rs1sel", 32'(rs1sel_o), 32'(e.rs1sel));
        chk("rs2sel", 32'(rs2sel_o), 32'(e.rs2sel));
        chk("memren", 32'(memren_o), 32'(e.memren));
        chk("memwren", 32'(memwren_o), 32'(e.memwren));
        chk("wbsel", 32'(wbsel_o), 32'(e.wbsel));
        chk("alusel", 32'(alusel_o), 32'(e.alusel));
        chk("brtaken", 32'(brtaken_o), 32'(e.br));
        chk("illegal", 32'(illegal_o), 32'(e.illegal));
        if (e.res_valid) chk("res", res_o, e.res);
    end

    // Present an instruction after a falling edge; return 1 unit after it latches.
    task automatic latch(input logic [31:0] insn, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        @(negedge clk);
        #2;
        insn_i = insn; pc_i = pc; rs1data_i = r1; rs2data_i = r2;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vec_insn [14];
    logic [31:0] vec_pc   [14];
    logic [31:0] vec_r1   [14];
    logic [31:0] vec_r2   [14];

    initial begin
        rst = 1'b1;
        insn_i = 32'h0; pc_i = 32'h0; rs1data_i = 32'h0000_0042; rs2data_i = 32'h0;
        #1;
        chk("reset pc_o", pc_o, 32'h0);
        chk("reset insn_o", insn_o, 32'h0000_0013);
        chk("reset res", res_o, 32'h0000_0042);
        #11;
        rst = 1'b0;

        latch(32'h0050_0093, 32'h0100_0000, 32'h0, 32'h0);
        chk("addi opcode", 32'(opcode_o), 32'h13);
        chk("addi rd", 32'(rd_o), 32'd1);
        chk("addi imm", imm_o, 32'd5);
        chk("addi res", res_o, 32'd5);
        chk("addi wbsel", 32'(wbsel_o), 32'd0);

        latch(32'h4020_8133, 32'h0100_0004, 32'd3, 32'd5);
        chk("sub alusel", 32'(alusel_o), 32'd1);
        chk("sub res", res_o, 32'hFFFF_FFFE);
        chk("sub regwren", 32'(regwren_o), 32'd1);

        latch(32'h0020_8463, 32'h0100_0010, 32'd7, 32'd7);
        chk("beq taken", 32'(brtaken_o), 32'd1);
        chk("beq target", res_o, 32'h0100_0018);
        rs2data_i = 32'd8;
        #1;
        chk("beq not taken", 32'(brtaken_o), 32'd0);

        latch(32'hFFC0_A183, 32'h0100_0014, 32'h0200_0010, 32'h0);
        chk("lw imm", imm_o, 32'hFFFF_FFFC);
        chk("lw res", res_o, 32'h0200_000C);
        chk("lw memren", 32'(memren_o), 32'd1);
        chk("lw wbsel", 32'(wbsel_o), 32'd1);

        latch(32'h0000_8067, 32'h0100_0018, 32'h0100_0105, 32'h0);
        chk("jalr res", res_o, 32'h0100_0104);
        chk("jalr brtaken", 32'(brtaken_o), 32'd1);
        chk("jalr pcsel", 32'(pcsel_o), 32'd1);
        chk("jalr wbsel", 32'(wbsel_o), 32'd2);

        latch(32'h4020_D1B3, 32'h0100_001C, 32'h8000_0010, 32'd4);
        chk("sra res", res_o, 32'hF800_0001);
        latch(32'h1234_50B7, 32'h0100_0020, 32'h0, 32'h0);
        chk("lui res", res_o, 32'h1234_5000);
        latch(32'h0000_1097, 32'h0100_0020, 32'h0, 32'h0);
        chk("auipc res", res_o, 32'h0100_1020);

        // Remaining coverage is checked by the model on each falling edge.
        vec_insn = '{32'h0020_B233, 32'h0020_A233, 32'h4030_D093, 32'hFFF0_C113,
                     32'h0020_A223, 32'h0020_9463, 32'h0020_C463, 32'h0020_F463,
                     32'hFE20_8EE3, 32'h0080_00EF, 32'hFFDF_F06F, 32'h0000_0073,
                     32'h0000_000F, 32'h0020_E433};
        vec_pc   = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118,
                     32'h11C, 32'h120, 32'h124, 32'h128, 32'h12C, 32'h130, 32'h134};
        vec_r1   = '{32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0F0F_0F0F, 32'h100,
                     32'd4, 32'hFFFF_FFFE, 32'd2, 32'd9, 32'd0, 32'd0, 32'd1, 32'd2,
                     32'hA5A5_0000};
        vec_r2   = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd77, 32'd4, 32'd3,
                     32'hFFFF_FFFF, 32'd9, 32'd0, 32'd0, 32'd1, 32'd2, 32'h0000_5A5A};
        for (int i = 0; i < 14; i++)
            latch(vec_insn[i], vec_pc[i], vec_r1[i], vec_r2[i]);

        // Reset mid-run with no clock edge.
        latch(32'h0080_00EF, 32'h0100_0040, 32'h0, 32'h0);
        #1;
        rs1data_i = 32'h55;
        rst = 1'b1;
        #1;
        chk("midrst pc_o", pc_o, 32'h0);
        chk("midrst insn_o", insn_o, 32'h0000_0013);
        chk("midrst res", res_o, 32'h55);
        chk("midrst regwren", 32'(regwren_o), 32'd1);
        chk("midrst rd", 32'(rd_o), 32'd0);
        chk("midrst brtaken", 32'(brtaken_o), 32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        latch(32'h0000_007F, 32'h0100_0050, 32'd3, 32'd4);
`ifdef ILLEGAL_INSN_EN
        chk("illegal flag", 32'(illegal_o), 32'd1);
`else
        chk("illegal flag", 32'(illegal_o), 32'd0);
`endif
        chk("illegal regwren", 32'(regwren_o), 32'd0);
        chk("illegal memren", 32'(memren_o), 32'd0);
        chk("illegal memwren", 32'(memwren_o), 32'd0);
        chk("illegal pcsel", 32'(pcsel_o), 32'd0);
        chk("illegal brtaken", 32'(brtaken_o), 32'd0);

        latch(32'h0000_0013, 32'h0100_0054, 32'd0, 32'd0);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
